// File: rtl/router_out_arbiter_pkg.sv
// Shared router definitions: port indices and the output-arbiter state encoding.
package router_out_arbiter_pkg;

  localparam int PORT_PE = 0;
  localparam int PORT_N  = 1;
  localparam int PORT_S  = 2;
  localparam int PORT_E  = 3;
  localparam int PORT_W  = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

endpackage

// File: rtl/router_out_arbiter_rr_pick.sv
// Round-robin search: first asserted request at or above ptr_i, wrapping modulo NUM_IN.
module rr_pick #(
  parameter int NUM_IN = 5,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0] req_i,
  input  logic [SEL_W-1:0]  ptr_i,
  output logic              valid_o,
  output logic [SEL_W-1:0]  idx_o
);

  localparam int SUM_W = SEL_W + 1;

  logic [NUM_IN-1:0] rot;
  logic [SEL_W-1:0]  ofs;
  logic [SUM_W-1:0]  sum;

  always_comb begin
    // Rotating the doubled vector puts ptr_i at bit 0, so the lowest set bit wins.
    rot     = NUM_IN'({req_i, req_i} >> ptr_i);
    valid_o = 1'b0;
    ofs     = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rot[i]) begin
        valid_o = 1'b1;
        ofs     = SEL_W'(i);
      end
    end
    sum = {1'b0, ptr_i} + {1'b0, ofs};
    if (sum >= SUM_W'(NUM_IN)) begin
      sum = sum - SUM_W'(NUM_IN);
    end
    idx_o = sum[SEL_W-1:0];
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Output-port arbiter: grants one input for a whole packet, round-robin between packets.
module router_out_arbiter
  import router_out_arbiter_pkg::*;
#(
  parameter int NUM_IN    = 5,
  parameter int MAX_FLITS = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_IN-1:0]         req,
  input  logic [NUM_IN-1:0]         last,
  input  logic                      out_ready,
  input  logic                      err_clr,
  output logic [NUM_IN-1:0]         grant,
  output logic [$clog2(NUM_IN)-1:0] sel,
  output logic                      xfer,
  output logic                      busy,
  output logic                      err_overrun
);

  localparam int SEL_W = $clog2(NUM_IN);
  localparam int CNT_W = $clog2(MAX_FLITS + 1);

  arb_state_e        state_q, state_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [SEL_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;

  logic              pick_valid;
  logic [SEL_W-1:0]  pick_idx;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .SEL_W  (SEL_W)
  ) u_rr_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SEL_W'(PORT_PE);
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    err_d   = err_q & ~err_clr;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = GRANT;
          grant_d = NUM_IN'(1) << pick_idx;
          sel_d   = pick_idx;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (xfer) begin
          if (cnt_q != CNT_W'(MAX_FLITS)) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
          // A packet that reaches MAX_FLITS without a tail is cut off and flagged.
          if (last[sel_q] || (cnt_q == CNT_W'(MAX_FLITS - 1))) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = (sel_q == SEL_W'(NUM_IN - 1)) ? '0 : sel_q + SEL_W'(1);
            if (!last[sel_q]) begin
              err_d = 1'b1;
            end
          end
        end
      end
    endcase
  end

  // Handshake: req[sel] is the valid and out_ready the ready; a flit moves on the
  // rising edge where busy, req[sel] and out_ready are all high (xfer).
  always_comb begin
    busy = (state_q == GRANT);
    xfer = busy & req[sel_q] & out_ready;
  end

  assign grant       = grant_q;
  assign sel         = sel_q;
  assign err_overrun = err_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter with a queue-based scoreboard and separate monitor.
module tb_router_out_arbiter;

  localparam int NUM_IN    = 5;
  localparam int MAX_FLITS = 8;
  localparam int SEL_W     = $clog2(NUM_IN);

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NUM_IN-1:0] req;
  logic [NUM_IN-1:0] last;
  logic              out_ready;
  logic              err_clr;
  logic [NUM_IN-1:0] grant;
  logic [SEL_W-1:0]  sel;
  logic              xfer;
  logic              busy;
  logic              err_overrun;

  router_out_arbiter #(
    .NUM_IN    (NUM_IN),
    .MAX_FLITS (MAX_FLITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .last        (last),
    .out_ready   (out_ready),
    .err_clr     (err_clr),
    .grant       (grant),
    .sel         (sel),
    .xfer        (xfer),
    .busy        (busy),
    .err_overrun (err_overrun)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [SEL_W-1:0]  exp_grant_q[$];
  logic [SEL_W:0]    exp_xfer_q[$];
  logic [NUM_IN:0]   exp_stat_q[$];

  // Source model: flits left per input, tail marking mode.
  int left[NUM_IN];
  bit has_last[NUM_IN];
  bit every[NUM_IN];
  bit toggle_ready = 1'b0;
  bit check_gap    = 1'b0;
  bit done         = 1'b0;
  int hits4        = 0;
  int timeouts     = 0;

  function automatic void push_g(input int p);
    exp_grant_q.push_back(SEL_W'(p));
  endfunction

  function automatic void push_x(input int p, input bit l);
    exp_xfer_q.push_back({SEL_W'(p), l});
  endfunction

  function automatic void push_stat(input bit e, input logic [NUM_IN-1:0] g);
    exp_stat_q.push_back({e, g});
  endfunction

  function automatic void set_pkt(input int p, input int n, input bit hl, input bit ev);
    left[p]     = n;
    has_last[p] = hl;
    every[p]    = ev;
  endfunction

  function automatic bit idle_all();
    bit r;
    r = (exp_grant_q.size() == 0) && (exp_xfer_q.size() == 0) && (exp_stat_q.size() == 0);
    for (int i = 0; i < NUM_IN; i++) begin
      if (left[i] != 0) r = 1'b0;
    end
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int i = 0; i < NUM_IN; i++) begin
      req[i]  = (left[i] > 0);
      last[i] = (left[i] > 0) && has_last[i] && (every[i] || (left[i] == 1));
    end
  endtask

  task automatic tick();
    logic             hit;
    logic [SEL_W-1:0] hs;
    @(negedge clk);
    hit = xfer;
    hs  = sel;
    @(posedge clk);
    #1;
    if (hit && (left[hs] > 0)) begin
      left[hs] = left[hs] - 1;
      if (hs == SEL_W'(4)) hits4++;
    end
    if (toggle_ready) out_ready = ~out_ready;
    drive();
  endtask

  task automatic drain(input int budget);
    for (int c = 0; c < budget; c++) begin
      if (idle_all()) break;
      tick();
    end
    if (!idle_all()) timeouts++;
  endtask

  task automatic do_reset();
    for (int i = 0; i < NUM_IN; i++) set_pkt(i, 0, 1'b0, 1'b0);
    out_ready    = 1'b1;
    err_clr      = 1'b0;
    toggle_ready = 1'b0;
    drive();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // ---------------- monitor / checker ----------------
  logic [NUM_IN-1:0] prev_grant = '0;
  int                idle_run   = 0;
  bit                gap_seen   = 1'b0;
  logic [SEL_W-1:0]  eg;
  logic [SEL_W:0]    ex;
  logic [NUM_IN:0]   es;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always begin : monitor
    @(negedge clk or negedge rst_n);
    if (!rst_n) begin
      #1;
      chk("rst_grant", int'(grant), 0);
      chk("rst_sel", int'(sel), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_xfer", int'(xfer), 0);
      chk("rst_err", int'(err_overrun), 0);
      prev_grant = '0;
      idle_run   = 0;
      gap_seen   = 1'b0;
    end else begin
      if (!check_gap) gap_seen = 1'b0;
      if ((grant != '0) && (grant != prev_grant)) begin
        if (exp_grant_q.size() == 0) begin
          chk("grant_unexpected", int'(grant), 0);
        end else begin
          eg = exp_grant_q.pop_front();
          chk("grant_onehot", int'(grant), 1 << eg);
          chk("grant_sel", int'(sel), int'(eg));
        end
        if (check_gap && gap_seen) chk("idle_gap", idle_run, 1);
        gap_seen = check_gap;
        idle_run = 0;
      end else if (grant == '0) begin
        idle_run++;
      end
      if (xfer) begin
        if (exp_xfer_q.size() == 0) begin
          chk("xfer_unexpected", int'(xfer), 0);
        end else begin
          ex = exp_xfer_q.pop_front();
          chk("xfer_sel_last", int'({sel, last[sel]}), int'(ex));
        end
      end
      if (exp_stat_q.size() != 0) begin
        es = exp_stat_q.pop_front();
        chk("err_overrun", int'(err_overrun), int'(es[NUM_IN]));
        chk("stat_grant", int'(grant), int'(es[NUM_IN-1:0]));
        chk("stat_busy", int'(busy), int'(|es[NUM_IN-1:0]));
      end
      prev_grant = grant;
      if (done) begin
        chk("grant_q_left", exp_grant_q.size(), 0);
        chk("xfer_q_left", exp_xfer_q.size(), 0);
        chk("stat_q_left", exp_stat_q.size(), 0);
        chk("wait_timeouts", timeouts, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin : driver
    req       = '0;
    last      = '0;
    out_ready = 1'b1;
    err_clr   = 1'b0;
    do_reset();

    // Two single-flit requesters, then probe the pointer left behind (3).
    set_pkt(1, 1, 1'b1, 1'b0);
    set_pkt(2, 1, 1'b1, 1'b0);
    push_g(1); push_x(1, 1'b1);
    push_g(2); push_x(2, 1'b1);
    drive();
    drain(40);
    set_pkt(0, 1, 1'b1, 1'b0);
    set_pkt(3, 1, 1'b1, 1'b0);
    push_g(3); push_x(3, 1'b1);
    push_g(0); push_x(0, 1'b1);
    drive();
    drain(40);

    // All five requesting, ten single-flit packets, one idle cycle between each.
    do_reset();
    check_gap = 1'b1;
    for (int i = 0; i < NUM_IN; i++) set_pkt(i, 2, 1'b1, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        push_g(i);
        push_x(i, 1'b1);
      end
    end
    drive();
    drain(80);
    check_gap = 1'b0;

    // Four-flit packet on input 3 with a stalling output and input 0 waiting.
    do_reset();
    set_pkt(3, 4, 1'b1, 1'b0);
    push_g(3);
    push_x(3, 1'b0); push_x(3, 1'b0); push_x(3, 1'b0); push_x(3, 1'b1);
    push_g(0); push_x(0, 1'b1);
    drive();
    for (int c = 0; c < 20; c++) begin
      if (busy) break;
      tick();
    end
    if (!busy) timeouts++;
    set_pkt(0, 1, 1'b1, 1'b1);
    out_ready    = 1'b0;
    toggle_ready = 1'b1;
    drive();
    drain(60);
    toggle_ready = 1'b0;
    out_ready    = 1'b1;

    // Eight flits with tail on the eighth: normal release, no overrun.
    do_reset();
    set_pkt(1, 8, 1'b1, 1'b0);
    push_g(1);
    for (int i = 0; i < 7; i++) push_x(1, 1'b0);
    push_x(1, 1'b1);
    drive();
    drain(40);
    push_stat(1'b0, 5'b00000);
    tick();

    // Nine flits without tail: cut after eight, re-granted for the ninth, then held.
    do_reset();
    set_pkt(2, 9, 1'b0, 1'b0);
    push_g(2);
    for (int i = 0; i < 8; i++) push_x(2, 1'b0);
    push_g(2); push_x(2, 1'b0);
    drive();
    drain(60);
    push_stat(1'b1, 5'b00100);
    tick();
    set_pkt(0, 1, 1'b1, 1'b1);
    drive();
    repeat (4) begin
      push_stat(1'b1, 5'b00100);
      tick();
    end
    set_pkt(0, 0, 1'b0, 1'b0);
    drive();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    push_stat(1'b0, 5'b00100);
    tick();

    // Reset asserted mid-packet on input 4, then arbitration restarts from input 0.
    do_reset();
    set_pkt(4, 4, 1'b1, 1'b0);
    push_g(4); push_x(4, 1'b0); push_x(4, 1'b0);
    hits4 = 0;
    drive();
    for (int c = 0; c < 20; c++) begin
      if (hits4 >= 2) break;
      tick();
    end
    if (hits4 < 2) timeouts++;
    #1;
    for (int i = 0; i < NUM_IN; i++) set_pkt(i, 0, 1'b0, 1'b0);
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_pkt(0, 1, 1'b1, 1'b1);
    set_pkt(4, 1, 1'b1, 1'b1);
    push_g(0); push_x(0, 1'b1);
    push_g(4); push_x(4, 1'b1);
    drive();
    tick();
    push_stat(1'b0, 5'b00001);
    drain(40);

    repeat (3) tick();
    done = 1'b1;
  end

endmodule

// File: doc/router_out_arbiter.md
ROUTER_OUT_ARBITER -- requirements
Module: router_out_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 5, meaning the number of requesting input ports, indexed 0=PE, 1=N, 2=S, 3=E, 4=W.
REQ-002 The block SHALL have parameter MAX_FLITS, default 8, meaning the maximum number of flits one packet may hold a grant for.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 The block SHALL have port req  input  NUM_IN  per-input flit-pending request.
REQ-006 The block SHALL have port last  input  NUM_IN  per-input tail-flit marker, meaningful only with req.
REQ-007 The block SHALL have port out_ready  input  1  downstream output channel can accept a flit this cycle.
REQ-008 The block SHALL have port err_clr  input  1  clears err_overrun.
REQ-009 The block SHALL have port grant  output  NUM_IN  registered one-hot grant, all-zero when idle.
REQ-010 The block SHALL have port sel  output  $clog2(NUM_IN)  registered index of the granted input, used as the output-mux select.
REQ-011 The block SHALL have port xfer  output  1  combinational flit-transfer strobe.
REQ-012 The block SHALL have port busy  output  1  high while in state GRANT.
REQ-013 The block SHALL have port err_overrun  output  1  sticky overrun flag.

Function
REQ-014 The FSM SHALL have exactly two states: IDLE and GRANT.
REQ-015 In IDLE with req nonzero, the block SHALL pick the first asserted req searching from index ptr upward, modulo NUM_IN. It SHALL then load grant and sel, clear the flit counter, and enter GRANT on the next edge (one-cycle arbitration latency).
REQ-016 In IDLE with req all-zero, the block SHALL stay in IDLE with grant=0.
REQ-017 xfer SHALL equal busy AND req[sel] AND out_ready, evaluated combinationally.
REQ-018 Each xfer SHALL increment the flit counter, which is $clog2(MAX_FLITS+1) bits wide and never wraps.
REQ-019 An xfer with last[sel]=1 SHALL, on that edge, return the FSM to IDLE, clear grant, and set ptr=(sel+1) mod NUM_IN.
REQ-020 An xfer without last, when the counter already equals MAX_FLITS-1, SHALL force the same release as REQ-019 and set err_overrun.
REQ-021 If last is asserted on the MAX_FLITS-th flit, the release SHALL be normal and err_overrun SHALL NOT be set.
REQ-022 In GRANT, if req[sel] deasserts before last, the block SHALL hold the grant indefinitely; other requesters SHALL NOT preempt.
REQ-023 In GRANT, req and last of non-granted inputs SHALL be ignored.
REQ-024 out_ready low SHALL stall the transfer with no state change.
REQ-025 After each packet there SHALL be exactly one IDLE cycle before the next grant, so sustained throughput is (L)/(L+1) for L-flit packets.
REQ-026 err_overrun SHALL remain set until err_clr=1 at a clock edge. If set and clear occur on the same edge, set SHALL win.
REQ-027 sel SHALL hold its last value in IDLE; grant is the authoritative validity indicator.

Reset
REQ-028 While rst_n=0, the block SHALL asynchronously force: state=IDLE, grant=0, sel=0, ptr=0, counter=0, err_overrun=0, busy=0.
REQ-029 When rst_n=0 during GRANT, the block SHALL drop the grant immediately with no xfer. The packet in progress is abandoned.
REQ-030 On rst_n rising, the first arbitration SHALL occur at the first clk edge after deassertion.

Structure
REQ-031 The port-index constants (PORT_PE, PORT_N, PORT_S, PORT_E, PORT_W) and the FSM state enum typedef SHALL live in the shared router package.
REQ-032 The round-robin priority search SHALL be a sub-module rr_pick, taking (req, ptr) and returning (valid, idx). It SHALL be purely combinational.

Verification
REQ-033 Bench SHALL cover: after reset, req=5'b00110 with 1-flit packets -> grant[1] first, then grant[2], ptr ends at 3.
REQ-034 Bench SHALL cover: req=5'b11111 held for 10 single-flit packets -> grant order 0,1,2,3,4,0,1,2,3,4 with one idle cycle between each.
REQ-035 Bench SHALL cover: input 3 sends a 4-flit packet while out_ready toggles 1,0,1,0 and req[0] is high -> exactly 4 xfers, no grant to input 0 until after last, then grant[4] is not issued and grant[0] follows.
REQ-036 Bench SHALL cover: input 2 sends 9 flits with no last, MAX_FLITS=8 -> forced release after the 8th xfer and err_overrun=1; err_clr pulse -> err_overrun=0.
REQ-037 Bench SHALL cover: input 1 sends 8 flits with last on the 8th -> normal release, err_overrun stays 0.
REQ-038 Bench SHALL cover: rst_n pulled low mid-packet on input 4 -> grant=0 asynchronously without waiting for a clock edge; after release with req=5'b10001 -> grant[0] first.
